// File: rtl/efuse_macro_emu_pkg.sv
// Shared types and constants for the eFuse macro emulator.
// Holds the FSM state encoding, the error codes and the byte-select helper.
package efuse_pkg;

  localparam int EFUSE_NBITS  = 256;
  localparam int EFUSE_NBYTES = 32;
  localparam int EFUSE_CNTW   = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD_SENSE,
    RD_HOLD,
    PG_BURN,
    PG_HOLD,
    ERR_WAIT
  } efuse_emu_state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BOTH_EN   = 3'd1,
    ERR_SHORT_RD  = 3'd2,
    ERR_SHORT_PGM = 3'd3,
    ERR_ADDR_CHG  = 3'd4,
    ERR_EN_CHG    = 3'd5
  } efuse_err_e;

  // Byte idx covers bits idx*8 .. idx*8+7, with the lowest bit index as LSB.
  function automatic logic [7:0] efuse_byte(input logic [EFUSE_NBITS-1:0] bits,
                                            input logic [4:0] idx);
    return bits[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/efuse_macro_emu_if.sv
// Fuse bus between the fuse controller (master) and the macro (slave).
interface efuse_macro_emu_if;
  import efuse_pkg::*;

  logic       pgmen;
  logic       rden;
  logic       aen;
  logic [7:0] addr;
  logic [7:0] rdata;

  modport master (output pgmen, rden, aen, addr, input rdata);
  modport slave  (input pgmen, rden, aen, addr, output rdata);

endinterface

// File: rtl/efuse_macro_emu_pulse_timer.sv
// Saturating strobe-width counter shared by the read and program paths.
// It reloads on start, clears on clear, advances on inc and holds otherwise.
module efuse_pulse_timer
  import efuse_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  inc_i,
  input  logic                  clear_i,
  input  logic [EFUSE_CNTW-1:0] target_i,
  output logic                  done_o
);

  logic [EFUSE_CNTW-1:0] cnt_q;
  logic [EFUSE_CNTW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = EFUSE_CNTW'(1);
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + EFUSE_CNTW'(1);
    end
  end

  // done fires on the sample that brings the count to target, so the caller acts on that same edge.
  assign done_o = (start_i || inc_i) && !clear_i && (cnt_d == target_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/efuse_macro_emu.sv
// Flop-based stand-in for the 256-bit OTP eFuse macro.
// It enforces the sense and burn strobe widths and flags protocol violations.
module efuse_macro_emu
  import efuse_pkg::*;
#(
  parameter int unsigned             P_TRD  = 3,
  parameter int unsigned             P_TPGM = 3,
  parameter logic [EFUSE_NBITS-1:0]  P_INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  efuse_macro_emu_if.slave       efuse,
  output logic [EFUSE_NBITS-1:0] fuse_bits_o,
  output logic [8:0]             pgm_cnt_o,
  output logic                   err_o,
  output logic [2:0]             err_code_o,
  input  logic                   err_clr_i
);

  localparam logic [EFUSE_CNTW-1:0] TRD  = EFUSE_CNTW'(P_TRD);
  localparam logic [EFUSE_CNTW-1:0] TPGM = EFUSE_CNTW'(P_TPGM);

  efuse_emu_state_t       state_q, state_d;
  logic [7:0]             addr_q, addr_d;
  logic                   rden_q, rden_d;
  logic                   pgmen_q, pgmen_d;
  logic [7:0]             rdata_q;
  logic [EFUSE_NBITS-1:0] fuse_q;
  logic [8:0]             pgm_cnt_q;
  logic                   err_q;
  efuse_err_e             err_code_q;

  logic                   tmr_start, tmr_inc, tmr_clear, tmr_done, rd_path;
  logic [EFUSE_CNTW-1:0]  tmr_target;
  logic                   rd_fire, pg_fire, err_set, addr_chg, en_chg;
  efuse_err_e             err_new;

  // Timer control depends only on state and inputs, keeping done free of loops through the FSM.
  always_comb begin
    tmr_start  = (state_q == IDLE) && efuse.aen && (efuse.rden ^ efuse.pgmen);
    tmr_inc    = ((state_q == RD_SENSE) || (state_q == PG_BURN)) && efuse.aen;
    tmr_clear  = (state_q != IDLE) && !efuse.aen;
    rd_path    = (state_q == IDLE) ? efuse.rden : (state_q == RD_SENSE);
    tmr_target = rd_path ? TRD : TPGM;
  end

  efuse_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (tmr_start),
    .inc_i    (tmr_inc),
    .clear_i  (tmr_clear),
    .target_i (tmr_target),
    .done_o   (tmr_done)
  );

  assign addr_chg = (efuse.addr != addr_q);
  assign en_chg   = ({efuse.rden, efuse.pgmen} != {rden_q, pgmen_q});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rden_d  = rden_q;
    pgmen_d = pgmen_q;
    rd_fire = 1'b0;
    pg_fire = 1'b0;
    err_set = 1'b0;
    err_new = ERR_NONE;
    unique case (state_q)
      IDLE: begin
        if (efuse.aen) begin
          if (efuse.rden && efuse.pgmen) begin
            err_set = 1'b1;
            err_new = ERR_BOTH_EN;
            state_d = ERR_WAIT;
          end else if (efuse.rden || efuse.pgmen) begin
            addr_d  = efuse.addr;
            rden_d  = efuse.rden;
            pgmen_d = efuse.pgmen;
            // A one-cycle minimum completes on the very first sample.
            if (tmr_done) begin
              rd_fire = efuse.rden;
              pg_fire = efuse.pgmen;
              state_d = efuse.rden ? RD_HOLD : PG_HOLD;
            end else begin
              state_d = efuse.rden ? RD_SENSE : PG_BURN;
            end
          end
        end
      end
      RD_SENSE, PG_BURN: begin
        if (!efuse.aen) begin
          err_set = 1'b1;
          err_new = (state_q == RD_SENSE) ? ERR_SHORT_RD : ERR_SHORT_PGM;
          state_d = IDLE;
        end else if (addr_chg) begin
          err_set = 1'b1;
          err_new = ERR_ADDR_CHG;
          state_d = ERR_WAIT;
        end else if (en_chg) begin
          err_set = 1'b1;
          err_new = ERR_EN_CHG;
          state_d = ERR_WAIT;
        end else if (tmr_done) begin
          rd_fire = (state_q == RD_SENSE);
          pg_fire = (state_q == PG_BURN);
          state_d = (state_q == RD_SENSE) ? RD_HOLD : PG_HOLD;
        end
      end
      RD_HOLD, PG_HOLD: begin
        if (!efuse.aen) begin
          state_d = IDLE;
        end else if (addr_chg) begin
          err_set = 1'b1;
          err_new = ERR_ADDR_CHG;
          state_d = ERR_WAIT;
        end else if (en_chg) begin
          err_set = 1'b1;
          err_new = ERR_EN_CHG;
          state_d = ERR_WAIT;
        end
      end
      ERR_WAIT: begin
        if (!efuse.aen) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      pgmen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rden_q  <= rden_d;
      pgmen_q <= pgmen_d;
    end
  end

  // Address is known stable when a pulse completes, so the live bus address selects the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      fuse_q    <= P_INIT;
      pgm_cnt_q <= '0;
    end else begin
      if (rd_fire) begin
        rdata_q <= efuse_byte(fuse_q, efuse.addr[7:3]);
      end
      if (pg_fire) begin
        fuse_q[efuse.addr] <= 1'b1;
        if (!fuse_q[efuse.addr] && (pgm_cnt_q != 9'd256)) begin
          pgm_cnt_q <= pgm_cnt_q + 9'd1;
        end
      end
    end
  end

  // A fresh error beats a simultaneous clear, and only the first error is kept until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (err_set) begin
      err_q <= 1'b1;
      if (!err_q || err_clr_i) begin
        err_code_q <= err_new;
      end
    end else if (err_clr_i) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end
  end

  assign efuse.rdata = rdata_q;
  assign fuse_bits_o = fuse_q;
  assign pgm_cnt_o   = pgm_cnt_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: doc/efuse_macro_emu.md
# efuse_macro_emu

Synthesizable emulator of the 256-bit one-time-programmable eFuse macro, the responder at the far end of the controller's fuse interface (pgmen/rden/aen/addr out, 8-bit rdata in). Used in FPGA prototypes and closed-loop sims in place of the hard macro. It:
- stores fuse bits in flops;
- enforces minimum sense and burn pulse widths;
- reports protocol violations.

## Interface
Parameters:
- P_TRD, 3: aen-high cycles required for a valid read sense (1..63)
- P_TPGM, 3: aen-high cycles required to burn one bit (1..1023)
- P_INIT, 256'h0: fuse contents after reset

Ports:
- clk  in  1  single clock; all inputs sampled on rising edge
- rst  in  1  reset, asynchronous, active-high
- efuse_pgmen_i  in  1  program enable
- efuse_rden_i  in  1  read enable
- efuse_aen_i  in  1  access strobe
- efuse_addr_i  in  8  read: byte index addr[7:3]; program: bit index addr[7:0]
- efuse_rdata_o  out  8  last sensed byte
- fuse_bits_o  out  256  current array contents (checker visibility)
- pgm_cnt_o  out  9  number of bits burned 0->1 since reset
- err_o  out  1  sticky protocol-error flag
- err_code_o  out  3  code of the first error since last clear
- err_clr_i  in  1  clears err_o and err_code_o

## Operation
- States: IDLE, RD_SENSE, RD_HOLD, PG_BURN, PG_HOLD, ERR_WAIT.
- Counter `cnt` is 10 bits and saturates. Address and enables are latched on entry to RD_SENSE / PG_BURN.

IDLE, on sampled aen=1:
- rden&pgmen both high: error code 1 -> ERR_WAIT.
- rden only: -> RD_SENSE, cnt=1.
- pgmen only: -> PG_BURN, cnt=1.
- neither: no action, stay IDLE.

RD_SENSE, each cycle aen=1 with addr/enables unchanged:
- cnt++.
- On the cycle cnt reaches P_TRD: efuse_rdata_o <= fuse[addr[7:3]*8 +: 8], LSB = lowest bit index; -> RD_HOLD.

PG_BURN, same rule with P_TPGM:
- On reaching P_TPGM, fuse[addr] <= 1.
- pgm_cnt_o++ only if that bit was 0. Re-burning a 1 leaves contents and count unchanged.
- -> PG_HOLD.

Aborts:
- aen falls in RD_SENSE before P_TRD: code 2 (short read), rdata unchanged, -> IDLE.
- aen falls in PG_BURN before P_TPGM: code 3 (short program), no bit change, -> IDLE.
- In any active state with aen=1, an addr change gives code 4 and an enable change gives code 5; abort, -> ERR_WAIT.

Return to IDLE:
- RD_HOLD, PG_HOLD, ERR_WAIT -> IDLE on aen=0.
- A longer-than-minimum pulse is legal; no further action while holding.

Errors:
- err_o sets on any error.
- err_code_o captures only the first error while err_o=0.
- New error in the same cycle as err_clr_i: error wins, and the code is the new one.

Bit rules:
- Bits only ever go 0->1. No path clears a fuse except rst.
- pgm_cnt_o saturates at 256.

## Timing
- Reset values: efuse_rdata_o=0, fuse_bits_o=P_INIT, pgm_cnt_o=0, err_o=0, err_code_o=0, state IDLE.
- Reset mid-pulse aborts with no bit burned. Non-volatility is not modeled: array returns to P_INIT.
- Read latency: aen first sampled high at edge E0 gives new efuse_rdata_o visible after edge E0+P_TRD-1. With P_TRD=3, data appears after the 3rd sampled-high edge.
- Program: fuse_bits_o and pgm_cnt_o update after edge E0+P_TPGM-1.
- efuse_rdata_o is registered and holds its value between reads, including through pgm pulses.
- Back-to-back accesses need at least one sampled aen=0 cycle; aen held high across an addr change is error 4.
- err_o asserts the cycle after the violating sample.

## Structure
- Package efuse_pkg:
  - EFUSE_NBITS=256, EFUSE_NBYTES=32
  - state enum efuse_emu_state_t
  - error-code enum efuse_err_e: NONE=0, BOTH_EN=1, SHORT_RD=2, SHORT_PGM=3, ADDR_CHG=4, EN_CHG=5
- One sub-module efuse_pulse_timer: 10-bit saturating counter with start/hold/clear and a compare-against-target done pulse, shared by the read and program paths.

## Test plan
- Read after reset, P_INIT byte 3 = 8'hA5: rden=1, addr=8'h18, aen high 3 cycles -> efuse_rdata_o=8'hA5 after 3rd edge, err_o=0.
- Program bit 8'h3F with pgmen, aen 3 cycles, then read addr 8'h38 -> rdata=8'h80, pgm_cnt_o=1. Re-program same bit -> pgm_cnt_o stays 1.
- Short pulses:
  - aen 2 cycles with rden (P_TRD=3) -> rdata unchanged, err_o=1, err_code_o=2.
  - After err_clr_i, aen 2 cycles with pgmen (P_TPGM=3) -> fuse unchanged, err_code_o=3.
- rden and pgmen both high with aen -> err_code_o=1, no read or burn. A second error before clear keeps code 1.
- addr changes from 8'h10 to 8'h11 on cycle 2 of a program pulse -> no burn, err_code_o=4. Then aen low for 1 cycle and a valid read succeeds.
- rst asserted on cycle 2 of a burn pulse -> all outputs at reset values immediately, fuse_bits_o=P_INIT.
